// File: rtl/pad_seq_pkg.sv
// rtl/pad_seq_pkg.sv - shared state, entry types and width helper for pad_sequencer
package pad_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } pad_state_e;

    // Entry fields are sized for the largest supported keypad and duration range.
    localparam int ENT_IDX_W = 8;
    localparam int ENT_DUR_W = 16;

    typedef struct packed {
        logic                 on;
        logic [ENT_IDX_W-1:0] idx;
        logic [ENT_DUR_W-1:0] dur;
    } pad_entry_t;

    function automatic int pad_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pad_seq_store.sv
// rtl/pad_seq_store.sv - DEPTH-entry note/rest store, synchronous write, registered read
module pad_seq_store
    import pad_seq_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = pad_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  pad_entry_t    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output pad_entry_t    o_rdata
);

    pad_entry_t r_mem [DEPTH];
    pad_entry_t r_rdata;

    // Write-first forwarding so a play request right after the last write sees fresh data.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pad_sequencer.sv
// rtl/pad_sequencer.sv - keypad record/playback sequencer; PAD_SEQ_LOOP_PLAYBACK_EN repeats playback until stop
module pad_sequencer
    import pad_seq_pkg::*;
#(
    parameter  int NUM_KEYS = 12,
    parameter  int DEPTH    = 32,
    parameter  int DUR_W    = 8,
    parameter  int TICK_DIV = 50000,
    localparam int IDX_W    = pad_width(NUM_KEYS),
    localparam int CNT_W    = pad_width(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                rec_start,
    input  logic                play_start,
    input  logic                stop,
    output logic                note_on,
    output logic [IDX_W-1:0]    note_idx,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    count,
    output logic                full
);

    localparam int               AW         = pad_width(DEPTH);
    localparam int               PW         = pad_width(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEPTH - 1);
`ifdef PAD_SEQ_LOOP_PLAYBACK_EN
    localparam bit               LOOP_EN    = 1'b1;
`else
    localparam bit               LOOP_EN    = 1'b0;
`endif

    pad_state_e       r_state;
    logic             r_note_on;
    logic [IDX_W-1:0] r_note_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic [PW-1:0]    r_presc;
    logic [DUR_W-1:0] r_dur;
    logic [ENT_DUR_W-1:0] r_cur_dur;
    logic [CNT_W-1:0] r_ptr;
    logic             r_seg_on;
    logic [IDX_W-1:0] r_seg_idx;

    logic             w_on;
    logic [IDX_W-1:0] w_idx;
    logic             w_code_chg;
    logic             w_wrap;
    logic             w_we;
    logic             w_last;
    logic [CNT_W-1:0] w_next;
    logic [AW-1:0]    w_raddr;
    pad_entry_t       w_wdata;
    pad_entry_t       w_rd;

    // Scanning downward leaves the lowest pressed key as the winner.
    always_comb begin
        w_on  = 1'b0;
        w_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                w_on  = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_code_chg  = (w_on != r_seg_on) || (w_idx != r_seg_idx);
        w_wrap      = (r_presc == PRESC_LAST);
        w_we        = (r_state == ST_REC) &&
                      (stop || w_code_chg || (w_wrap && (r_dur == DUR_MAX)));
        w_next      = r_ptr + CNT_W'(1);
        w_last      = (w_next == r_count);
        w_raddr     = ((r_state == ST_PLAY) && !w_last) ? w_next[AW-1:0] : '0;
        w_wdata     = '0;
        w_wdata.on  = r_seg_on;
        w_wdata.idx = ENT_IDX_W'(r_seg_idx);
        w_wdata.dur = ENT_DUR_W'(r_dur);
    end

    pad_seq_store #(.DEPTH(DEPTH)) u_store (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_waddr (r_count[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rd)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_note_on  <= 1'b0;
            r_note_idx <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_presc    <= '0;
            r_dur      <= '0;
            r_cur_dur  <= '0;
            r_ptr      <= '0;
            r_seg_on   <= 1'b0;
            r_seg_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_note_on  <= w_on;
                    r_note_idx <= w_idx;
                    if (!stop && rec_start) begin
                        r_state   <= ST_REC;
                        r_count   <= '0;
                        r_full    <= 1'b0;
                        r_seg_on  <= w_on;
                        r_seg_idx <= w_idx;
                        r_presc   <= '0;
                        r_dur     <= DUR_W'(1);
                    end else if (!stop && play_start && (r_count != '0)) begin
                        r_state    <= ST_PLAY;
                        r_note_on  <= w_rd.on;
                        r_note_idx <= w_rd.idx[IDX_W-1:0];
                        r_cur_dur  <= w_rd.dur;
                        r_ptr      <= '0;
                        r_presc    <= '0;
                        r_dur      <= DUR_W'(1);
                    end
                end
                ST_REC: begin
                    r_note_on  <= w_on;
                    r_note_idx <= w_idx;
                    if (w_we) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_code_chg) begin
                        r_seg_on  <= w_on;
                        r_seg_idx <= w_idx;
                        r_presc   <= '0;
                        r_dur     <= DUR_W'(1);
                    end else if (w_wrap) begin
                        r_presc <= '0;
                        r_dur   <= (r_dur == DUR_MAX) ? DUR_W'(1) : r_dur + DUR_W'(1);
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                    if (w_we && (r_count == CNT_LAST)) begin
                        r_full  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state    <= ST_IDLE;
                        r_note_on  <= w_on;
                        r_note_idx <= w_idx;
                    end else if (w_wrap) begin
                        r_presc <= '0;
                        if (ENT_DUR_W'(r_dur) == r_cur_dur) begin
                            r_dur <= DUR_W'(1);
                            if (w_last && !LOOP_EN) begin
                                r_state    <= ST_IDLE;
                                r_note_on  <= w_on;
                                r_note_idx <= w_idx;
                            end else begin
                                // Prefetched entry is already waiting in the store output.
                                r_note_on  <= w_rd.on;
                                r_note_idx <= w_rd.idx[IDX_W-1:0];
                                r_cur_dur  <= w_rd.dur;
                                r_ptr      <= w_last ? '0 : w_next;
                            end
                        end else begin
                            r_dur <= r_dur + DUR_W'(1);
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign note_on  = r_note_on;
    assign note_idx = r_note_idx;
    assign state    = r_state;
    assign count    = r_count;
    assign full     = r_full;

endmodule

// File: doc/pad_sequencer.md
# pad_sequencer

Parametrised record/playback sequencer for the launch-pad keypad. It samples `NUM_KEYS` key levels, priority-encodes them, and records each key-change segment as a note/rest entry with a tick-quantised duration into an internal `DEPTH`-entry store. It replays the store with exact per-entry durations, replacing the fixed 12-button single-address SRAM path. It sits between the debounced keypad and the tone generators: `note_on`/`note_idx` drive the tone converter enables.

## Interface
- `NUM_KEYS`, 12: number of key inputs; `IDX_W = $clog2(NUM_KEYS)`.
- `DEPTH`, 32: entries in the sequence store; `CNT_W = $clog2(DEPTH+1)`.
- `DUR_W`, 8: duration field width, in ticks.
- `TICK_DIV`, 50000: clock cycles per tick (≥2).
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `keys`  in  `NUM_KEYS`  key levels, already synchronised and debounced; 1 = pressed.
- `rec_start`  in  1  one-cycle pulse that starts recording.
- `play_start`  in  1  one-cycle pulse that starts playback.
- `stop`  in  1  one-cycle pulse that ends recording or playback.
- `note_on`  out  1  note active (0 = rest or silent).
- `note_idx`  out  `IDX_W`  active key index; 0 when `note_on=0`.
- `state`  out  2  IDLE=0, REC=1, PLAY=2.
- `count`  out  `CNT_W`  number of valid stored entries.
- `full`  out  1  store filled during the last recording.

## Operation
- **Key encoding:** the lowest-index pressed key wins. Code = {on, idx}; no key pressed gives on=0, idx=0.
- **IDLE:** `note_on`/`note_idx` follow the live code, registered with 1-cycle latency.
  - `rec_start` → REC; clears `count` and `full`.
  - `play_start` with `count>0` → PLAY. With `count=0` it is ignored.
- **REC:** outputs stay on live monitor.
  - A segment starts at REC entry and at every code change. At segment start the prescaler is 0 and `dur=1`.
  - Each prescaler wrap while the code is unchanged does `dur++`.
  - On a code change, write entry {on, idx, dur} of the ended segment; `count++`.
  - If `dur` reaches 2^DUR_W−1 and another wrap occurs, write the entry and restart the segment with the same code (split).
  - `stop` writes the open segment, then → IDLE.
  - When the write that makes `count==DEPTH` occurs: set `full=1` → IDLE. Further events are dropped.
- **PLAY:** entries 0..count−1 drive the outputs in order. Entry k holds for exactly dur_k·TICK_DIV cycles. The next entry is prefetched, so there are no gap cycles. After the last entry → IDLE, with outputs back on live monitor.
- **Priority:** `stop` > `rec_start` > `play_start`.
  - `rec_start`/`play_start` are ignored outside IDLE.
  - A `stop` in IDLE is ignored.
- **Storage:** store contents are not reset. `count`/`full` are reset.

## Timing
- **Reset values:** `note_on=0`, `note_idx=0`, `state=IDLE`, `count=0`, `full=0`. The prescaler and pointers clear. Async assertion mid-REC/PLAY aborts immediately; the partial segment is lost.
- **Play latency:** `play_start` at cycle t → `state=PLAY` and entry 0 on the outputs at t+1.
- **Recorded durations:** a segment of c cycles records dur = ceil(c/TICK_DIV), minimum 1. When a code change coincides with a prescaler wrap, the change wins and no increment occurs.
- **Stop during play:** `stop` at t → `note_on=0` at t+1 (live monitor).
- **Record writes:** `count` updates the cycle after the write.

## Configuration
- **`PAD_SEQ_LOOP_PLAYBACK_EN`** defined: after the last entry, playback wraps to entry 0 with no gap cycle and repeats until `stop`.
- Undefined: a single pass, then IDLE.
- Ports are identical in both builds.

## Structure
- **`pad_seq_pkg`:**
  - state enum (IDLE/REC/PLAY).
  - entry struct {on, idx, dur}.
  - a width helper function for `IDX_W`/`CNT_W`.
- **Sub-module `pad_seq_store`:**
  - `DEPTH`×entry register array.
  - synchronous write; registered read at an address with 1-cycle latency, used for prefetch.
- The top level holds the FSM, prescaler, duration counter and key encoder.

## Test plan
All cases use TICK_DIV=4 and reset first.
- **Reset:** assert `RST=0` mid-PLAY → all outputs at their reset values immediately; `count=0` after release.
- **Record:** `rec_start`; key 3 for 8 cycles, none for 4, keys {0,5} for 3, then `stop` → `count=3`; entries {1,3,2}, {0,0,1}, {1,0,1}.
- **Play:** `play_start` on the above store → `note_on=1`, `idx=3` for 8 cycles; then 0 for 4; then `idx=0` for 4; then IDLE with `note_on=0`.
- **Full:** with DEPTH=4, five key changes → `count=4`, `full=1`, `state=IDLE`; the 5th segment is not stored.
- **Saturation:** with DUR_W=2, key 7 held 20 cycles then `stop` → entries {1,7,3}, {1,7,2}.
- **Priority and loop:** `stop`+`play_start` in the same cycle during PLAY → IDLE. With `PAD_SEQ_LOOP_PLAYBACK_EN`, 3 entries replay continuously with entry 0 reappearing exactly after the sum of durations.
